// File: rtl/srio_rx_depad_if.sv
// Command, padded payload and depadded output handshakes of the SRIO receive depadder.
// master drives commands and payload beats; slave is the depadder.
interface srio_rx_depad_if #(
   parameter int LEN_W = 20
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [LEN_W-1:0] cmd_len;
   logic [63:0]      in_data;
   logic             in_valid;
   logic             in_last;
   logic             in_ready;
   logic [63:0]      out_data;
   logic [7:0]       out_keep;
   logic             out_valid;
   logic             out_last;
   logic             out_ready;

   modport master (
      output cmd_valid, cmd_len, in_data, in_valid, in_last, out_ready,
      input  cmd_ready, in_ready, out_data, out_keep, out_valid, out_last
   );

   modport slave (
      input  cmd_valid, cmd_len, in_data, in_valid, in_last, out_ready,
      output cmd_ready, in_ready, out_data, out_keep, out_valid, out_last
   );
endinterface

// File: rtl/srio_rx_depad.sv
// Strips SRIO length padding: passes the first len+1 bytes of a padded beat stream with keep/last,
// discards pad beats, and aborts with a len_err pulse when packet framing disagrees with the command.
module srio_rx_depad #(
   parameter int LEN_W = 20
) (
   input  logic                  clk,
   input  logic                  reset,
   srio_rx_depad_if.slave        bus,
   output logic                  busy,
   output logic                  len_err
);
   localparam int TW = LEN_W - 8;
   localparam int VW = LEN_W - 3;
   localparam logic [TW-1:0] T_ONE = 1;
   localparam logic [VW-1:0] V_ONE = 1;

   typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

   state_t          state, state_nxt;
   logic [TW-1:0]   times_r, pkt_cnt;
   logic [4:0]      fb_m1, beat_cnt, exp_beat, fb_m1_nxt;
   logic [VW-1:0]   vb_m1, vcnt;
   logic [7:0]      last_keep;
   logic            vdone;
   logic            cmd_rdy, in_rdy, cmd_acc, in_acc;
   logic            is_final, is_vb, frame_bad, frame_err;
   logic [3:0]      keep_n;

   assign bus.cmd_ready = cmd_rdy;
   assign bus.in_ready  = in_rdy;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cmd_rdy   = 1'b0;
      in_rdy    = 1'b0;
      busy      = (state != IDLE);
      is_final  = (pkt_cnt == times_r);
      is_vb     = (vcnt == vb_m1);
      exp_beat  = is_final ? fb_m1 : 5'd31;
      frame_bad = (bus.in_last != (beat_cnt == exp_beat));
      keep_n    = {1'b0, bus.cmd_len[2:0]} + 4'd1;

      // Final packet is rounded up to a power of two between 8 and 256 bytes.
      if      (bus.cmd_len[7]) fb_m1_nxt = 5'd31;
      else if (bus.cmd_len[6]) fb_m1_nxt = 5'd15;
      else if (bus.cmd_len[5]) fb_m1_nxt = 5'd7;
      else if (bus.cmd_len[4]) fb_m1_nxt = 5'd3;
      else if (bus.cmd_len[3]) fb_m1_nxt = 5'd1;
      else                     fb_m1_nxt = 5'd0;

      case (state)
         IDLE: cmd_rdy = !reset;
         PASS: in_rdy  = (!bus.out_valid || bus.out_ready) && !vdone;
         DROP: in_rdy  = 1'b1;
         default: ;
      endcase

      cmd_acc   = bus.cmd_valid && cmd_rdy;
      in_acc    = bus.in_valid && in_rdy;
      frame_err = in_acc && frame_bad;

      case (state)
         IDLE: if (cmd_acc) state_nxt = PASS;
         PASS: begin
            if (frame_err)                              state_nxt = IDLE;
            else if (in_acc && is_vb && !bus.in_last)   state_nxt = DROP;
            // vdone keeps a previous transfer's draining last beat from ending this one.
            else if (vdone && bus.out_valid && bus.out_ready && bus.out_last)
                                                        state_nxt = IDLE;
         end
         DROP: if (frame_err || (in_acc && bus.in_last && is_final)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         times_r       <= '0;
         pkt_cnt       <= '0;
         fb_m1         <= '0;
         beat_cnt      <= '0;
         vb_m1         <= '0;
         vcnt          <= '0;
         last_keep     <= '0;
         vdone         <= 1'b0;
         len_err       <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_last  <= 1'b0;
         bus.out_keep  <= '0;
         bus.out_data  <= '0;
      end else begin
         len_err <= frame_err;
         if (cmd_acc) begin
            times_r   <= bus.cmd_len[LEN_W-1:8];
            fb_m1     <= fb_m1_nxt;
            vb_m1     <= bus.cmd_len[LEN_W-1:3];
            last_keep <= ~(8'hFF >> keep_n);
            pkt_cnt   <= '0;
            beat_cnt  <= '0;
            vcnt      <= '0;
            vdone     <= 1'b0;
         end else if (in_acc && !frame_bad) begin
            beat_cnt <= bus.in_last ? 5'd0 : beat_cnt + 5'd1;
            if (bus.in_last) pkt_cnt <= pkt_cnt + T_ONE;
            if (state == PASS) begin
               vcnt <= vcnt + V_ONE;
               if (is_vb && bus.in_last) vdone <= 1'b1;
            end
         end

         if (in_acc && !frame_bad && state == PASS) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= bus.in_data;
            bus.out_keep  <= is_vb ? last_keep : 8'hFF;
            bus.out_last  <= is_vb;
         end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_srio_rx_depad.sv
// Bench for srio_rx_depad: random payload bytes, padded stream built from packet-size rules,
// expected output derived byte-wise from the transfer length.
module tb_srio_rx_depad;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic busy, len_err;
   always #5 clk = ~clk;

   srio_rx_depad_if bus ();
   srio_rx_depad dut (.clk(clk), .reset(reset), .bus(bus), .busy(busy), .len_err(len_err));

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
   } beat_t;

   int    checks = 0;
   int    failures = 0;
   beat_t exp_q[$];
   beat_t got_q[$];
   int    n_err, n_ign, n_last, timeout, busy_start;

   // rmode: 0 ready always, 1 ready toggling, 2 ready random. flip: beat index whose in_last is inverted (-1 none).
   task automatic run_xfer(input int len, input int rmode, input int flip, input bit hold_cmd);
      byte unsigned pay[$];
      logic [63:0]  in_d[$];
      bit           in_l[$];
      int           times, fbytes, sz, nin, nvb, lim, idx;
      bit           stop, acc_in, done;
      logic [63:0]  d;
      beat_t        e;

      exp_q.delete(); got_q.delete();
      n_err = 0; n_ign = 0; n_last = 0; timeout = 0; idx = 0; stop = 0; done = 0;
      times  = len / 256;
      fbytes = len + 1 - times * 256;
      sz = 8;
      while (sz < fbytes) sz = sz * 2;
      for (int i = 0; i < times * 256 + sz; i++) pay.push_back(8'($urandom));
      nin = (times * 256 + sz) / 8;
      for (int b = 0; b < nin; b++) begin
         d = '0;
         for (int k = 0; k < 8; k++) d = {d[55:0], pay[b*8+k]};
         in_d.push_back(d);
         in_l.push_back((((b + 1) % 32) == 0) || (b == nin - 1));
      end
      if (flip >= 0) in_l[flip] = !in_l[flip];

      nvb = (len + 8) / 8;
      lim = (flip >= 0 && flip < nvb) ? flip : nvb;
      for (int b = 0; b < lim; b++) begin
         e.d = in_d[b];
         for (int k = 0; k < 8; k++) e.k[7-k] = ((b * 8 + k) <= len);
         e.l = (b == nvb - 1) && (flip < 0);
         exp_q.push_back(e);
      end

      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_len   = 20'(len);
      #1;
      if (!bus.cmd_ready) timeout = 1;
      @(posedge clk);
      #1 busy_start = busy;

      for (int c = 0; c < 20000 && !done; c++) begin
         @(negedge clk);
         bus.cmd_valid = hold_cmd && (idx < nin);
         bus.cmd_len   = 20'(len) ^ 20'h5A5A5;
         bus.out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? c[0] : 1'($urandom_range(0, 1));
         if (!stop && idx < nin) begin
            bus.in_valid = 1'b1;
            bus.in_data  = in_d[idx];
            bus.in_last  = in_l[idx];
         end else begin
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
         end
         #1;
         acc_in = bus.in_valid && bus.in_ready;
         if (bus.out_valid && bus.out_ready) begin
            got_q.push_back({bus.out_data, bus.out_keep, bus.out_last});
            if (bus.out_last) n_last++;
         end
         if (len_err) n_err++;
         if (bus.cmd_valid && bus.cmd_ready) n_ign++;
         done = (stop || idx == nin) && !bus.out_valid && !busy;
         if (!done) begin
            @(posedge clk);
            if (acc_in) begin
               if (idx == flip) stop = 1;
               idx++;
            end
         end
      end
      if (!done) timeout = 1;
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.out_ready = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      checks++; if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=0", bus.cmd_ready); end
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
      checks++; if ({bus.out_valid, bus.out_last, bus.out_keep, bus.out_data} !== 74'd0)
         begin failures++; $display("FAIL reset_out got v=%b l=%b k=%h d=%h exp zeros", bus.out_valid, bus.out_last, bus.out_keep, bus.out_data); end
      checks++; if ({busy, len_err} !== 2'b00) begin failures++; $display("FAIL reset_busy_err got=%b%b exp=00", busy, len_err); end
      reset = 1'b0;
      @(negedge clk); #1;
      checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL idle_cmd_ready got=%b exp=1", bus.cmd_ready); end
   endtask

   task automatic test_single_byte();
      run_xfer(0, 0, -1, 1'b0);
      checks++; if (got_q.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", got_q.size()); end
      checks++; if (got_q.size() > 0 && (got_q[0].k !== 8'h80 || got_q[0].l !== 1'b1 || got_q[0] !== exp_q[0]))
         begin failures++; $display("FAIL single_beat got=%h exp=%h", got_q[0], exp_q[0]); end
      checks++; if (busy !== 1'b0 || n_err != 0 || timeout != 0) begin failures++; $display("FAIL single_end busy=%b err=%0d to=%0d exp 0/0/0", busy, n_err, timeout); end
   endtask

   task automatic test_short();
      run_xfer(13, 2, -1, 1'b0);
      checks++; if (got_q.size() != 2) begin failures++; $display("FAIL short_count got=%0d exp=2", got_q.size()); end
      foreach (exp_q[i]) begin
         checks++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin failures++; $display("FAIL short_beat %0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (got_q.size() == 2 && {got_q[0].k, got_q[1].k, got_q[0].l, got_q[1].l} !== {8'hFF, 8'hFC, 2'b01})
         begin failures++; $display("FAIL short_keep got=%h/%h exp=ff/fc", got_q[0].k, got_q[1].k); end
   endtask

   task automatic test_full_packet();
      run_xfer(255, 0, -1, 1'b0);
      checks++; if (got_q.size() != 32 || n_last != 1) begin failures++; $display("FAIL full_count got=%0d lasts=%0d exp=32/1", got_q.size(), n_last); end
      foreach (exp_q[i]) begin
         checks++; if (i >= got_q.size() || got_q[i] !== exp_q[i] || got_q[i].k !== 8'hFF)
            begin failures++; $display("FAIL full_beat %0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (n_err != 0 || timeout != 0) begin failures++; $display("FAIL full_err got=%0d/%0d exp=0/0", n_err, timeout); end
   endtask

   task automatic test_pad();
      run_xfer(300, 0, -1, 1'b1);
      checks++; if (busy_start !== 1'b1) begin failures++; $display("FAIL pad_busy_start got=%b exp=1", busy_start); end
      checks++; if (got_q.size() != 38) begin failures++; $display("FAIL pad_count got=%0d exp=38", got_q.size()); end
      foreach (exp_q[i]) begin
         checks++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin failures++; $display("FAIL pad_beat %0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (got_q.size() == 38 && (got_q[37].k !== 8'hF8 || got_q[37].l !== 1'b1))
         begin failures++; $display("FAIL pad_last got k=%h l=%b exp k=f8 l=1", got_q[37].k, got_q[37].l); end
      checks++; if (n_ign != 0) begin failures++; $display("FAIL pad_cmd_ignored got=%0d accepts exp=0", n_ign); end
      checks++; if (busy !== 1'b0 || bus.cmd_ready !== 1'b1 || n_err != 0 || timeout != 0)
         begin failures++; $display("FAIL pad_end busy=%b cmd_ready=%b err=%0d to=%0d exp 0/1/0/0", busy, bus.cmd_ready, n_err, timeout); end
   endtask

   task automatic test_backpressure();
      run_xfer(300, 1, -1, 1'b0);
      checks++; if (got_q.size() != 38 || n_last != 1) begin failures++; $display("FAIL bp_count got=%0d lasts=%0d exp=38/1", got_q.size(), n_last); end
      foreach (exp_q[i]) begin
         checks++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_beat %0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_early_last();
      run_xfer(13, 0, 0, 1'b0);
      checks++; if (n_err != 1) begin failures++; $display("FAIL early_len_err got=%0d pulses exp=1", n_err); end
      checks++; if (got_q.size() != 0 || n_last != 0) begin failures++; $display("FAIL early_out got=%0d beats lasts=%0d exp=0/0", got_q.size(), n_last); end
      checks++; if (bus.cmd_ready !== 1'b1 || timeout != 0) begin failures++; $display("FAIL early_idle cmd_ready=%b to=%0d exp 1/0", bus.cmd_ready, timeout); end
   endtask

   task automatic test_missing_last();
      run_xfer(300, 2, 31, 1'b0);
      checks++; if (n_err != 1 || n_last != 0) begin failures++; $display("FAIL missing_err got=%0d lasts=%0d exp=1/0", n_err, n_last); end
      checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL missing_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         checks++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin failures++; $display("FAIL missing_beat %0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_back_to_back();
      int lens[3] = '{7, 8, 520};
      for (int t = 0; t < 3; t++) begin
         run_xfer(lens[t], 2, -1, 1'b0);
         checks++; if (got_q.size() != exp_q.size() || n_err != 0 || timeout != 0)
            begin failures++; $display("FAIL b2b_%0d got=%0d err=%0d to=%0d exp=%0d/0/0", t, got_q.size(), n_err, timeout, exp_q.size()); end
         foreach (exp_q[i]) begin
            checks++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_%0d_beat %0d got=%h exp=%h", t, i, got_q[i], exp_q[i]); end
         end
      end
   endtask

   task automatic test_random();
      int len;
      for (int t = 0; t < 6; t++) begin
         len = $urandom_range(0, 2100);
         run_xfer(len, $urandom_range(0, 2), -1, 1'b0);
         checks++; if (got_q.size() != exp_q.size() || n_last != 1 || n_err != 0 || timeout != 0)
            begin failures++; $display("FAIL rand len=%0d got=%0d lasts=%0d err=%0d to=%0d exp=%0d/1/0/0", len, got_q.size(), n_last, n_err, timeout, exp_q.size()); end
         foreach (exp_q[i]) begin
            checks++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand len=%0d beat %0d got=%h exp=%h", len, i, got_q[i], exp_q[i]); end
         end
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_len   = 20'd300;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1;
         bus.in_last  = 1'b0;
         bus.in_data  = {$urandom, $urandom};
         @(negedge clk);
      end
      #1;
      checks++; if (busy !== 1'b1 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL mid_pre busy=%b out_valid=%b exp 1/1", busy, bus.out_valid); end
      reset = 1'b1;
      @(posedge clk); #1;
      checks++; if ({busy, bus.out_valid, bus.out_keep, bus.in_ready, bus.cmd_ready} !== 12'd0)
         begin failures++; $display("FAIL mid_reset busy=%b ov=%b k=%h ir=%b cr=%b exp zeros", busy, bus.out_valid, bus.out_keep, bus.in_ready, bus.cmd_ready); end
      @(negedge clk);
      reset = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL mid_idle cmd_ready=%b exp=1", bus.cmd_ready); end
      run_xfer(13, 0, -1, 1'b0);
      checks++; if (got_q.size() != 2 || n_err != 0 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1])
         begin failures++; $display("FAIL mid_after got=%0d beats err=%0d exp 2/0", got_q.size(), n_err); end
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_len   = '0;
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      test_reset();
      test_single_byte();
      test_short();
      test_full_packet();
      test_pad();
      test_backpressure();
      test_early_last();
      test_missing_last();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
